m_shift_arbiter: RTL and testbench



---
 rtl/m_shift_arbiter_pkg.sv | 24 ++
 rtl/m_shift_arbiter_if.sv | 28 ++
 rtl/m_shift_arbiter_rr_pick.sv | 27 ++
 rtl/m_shift_arbiter.sv | 119 +++++++++++
 tb/tb_m_shift_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_shift_arbiter_pkg.sv
// Shared types for the shift arbiter: shift descriptor, shift-type enum and arbiter FSM states.
package p_common;

  localparam int SHIFT_AMT_W = 5;

  // 3-bit type field so that codes 4..7 exist and mean "pass data through"
  typedef enum logic [2:0] {
    SHIFT_SHL = 3'd0,
    SHIFT_SHR = 3'd1,
    SHIFT_ASL = 3'd2,
    SHIFT_ASR = 3'd3
  } e_shift_type;

  typedef struct packed {
    e_shift_type             shift_type;
    logic [SHIFT_AMT_W-1:0]  amt;
  } s_shift;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } e_arb_state;

endpackage

// File: rtl/m_shift_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters (master) and the shift arbiter (slave).
interface m_shift_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
);
  import p_common::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][31:0]      req_data;
  s_shift [NUM_REQ-1:0]          req_shift;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [31:0]                   rsp_data;
  logic [TAG_W-1:0]              rsp_tag;
  logic [NUM_REQ-1:0]            rsp_ready;

  modport master (
    output req_valid, req_data, req_shift, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_data, req_shift, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );

endinterface

// File: rtl/m_shift_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module m_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_shift_arbiter.sv
// Round-robin shared barrel shifter with one registered operand stage.
// Define SHIFT_ARB_PIPE_EN to re-arbitrate in RESP on the owner's accept (1 op/cycle).
module m_shift_arbiter
  import p_common::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input logic              clk,
  input logic              rst,
  m_shift_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  e_arb_state         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [31:0]        data_q, data_d;
  s_shift             shift_q, shift_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_valid;
  logic [PTR_W-1:0]   grant_idx;
  logic               arb_en;
  logic               accept;
  logic               owner_done;

  function automatic logic [31:0] shift_op(input logic [31:0] d, input s_shift s);
    case (s.shift_type)
      SHIFT_SHL, SHIFT_ASL: shift_op = d << s.amt;
      SHIFT_SHR:            shift_op = d >> s.amt;
      SHIFT_ASR:            shift_op = $unsigned($signed(d) >>> s.amt);
      default:              shift_op = d;
    endcase
  endfunction

  m_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  assign owner_done = (state_q == ARB_RESP) && bus.rsp_ready[owner_q];

  // Arbitration is blocked while rst is high so no requester sees a phantom accept
  always_comb begin
    arb_en = (state_q == ARB_IDLE);
`ifdef SHIFT_ARB_PIPE_EN
    if (owner_done) arb_en = 1'b1;
`endif
    if (rst) arb_en = 1'b0;
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) grant_idx = PTR_W'(i);
    end
  end

  assign accept = arb_en && pick_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_RESP;
      ARB_RESP: if (owner_done) state_d = accept ? ARB_RESP : ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    shift_d = shift_q;
    tag_d   = tag_q;
    if (accept) begin
      owner_d = grant_idx;
      ptr_d   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      data_d  = bus.req_data[grant_idx];
      shift_d = bus.req_shift[grant_idx];
      tag_d   = bus.req_tag[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      shift_q <= '0;
      tag_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    bus.req_ready = arb_en ? pick_grant : '0;
    bus.rsp_valid = '0;
    if (state_q == ARB_RESP) bus.rsp_valid[owner_q] = 1'b1;
    bus.rsp_data  = shift_op(data_q, shift_q);
    bus.rsp_tag   = tag_q;
  end

endmodule

// File: tb/tb_m_shift_arbiter.sv
// Self-checking bench for m_shift_arbiter: grants push expected results, responses pop and compare.
// Build with SHIFT_ARB_PIPE_EN defined to check the pipelined variant.
module tb_m_shift_arbiter;
  import p_common::*;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 4;
`ifdef SHIFT_ARB_PIPE_EN
  localparam int GRANT_GAP = 1;
  localparam int BP_WAIT   = 0;
`else
  localparam int GRANT_GAP = 2;
  localparam int BP_WAIT   = 1;
`endif

  typedef struct {
    int               owner;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;
  logic expectRsp  = 1'b0;
  exp_t sb[$];
  int   grantLog[$];
  int   grantCyc[$];

  m_shift_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  m_shift_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
  endtask

  // Reference shifter built from masks rather than arithmetic shifts
  function automatic logic [31:0] modelShift(input logic [31:0] d, input logic [2:0] ty, input logic [4:0] amt);
    logic [31:0] ones;
    ones = '1;
    case (ty)
      3'd0, 3'd2: modelShift = d << amt;
      3'd1:       modelShift = d >> amt;
      3'd3:       modelShift = (d >> amt) | (d[31] ? ~(ones >> amt) : 32'd0);
      default:    modelShift = d;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      expectRsp = 1'b0;
    end else begin
      if (expectRsp) checkOutput("rsp_latency", {63'd0, |bus.rsp_valid}, 64'd1);
      checkOutput("req_ready_onehot", {63'd0, $onehot0(bus.req_ready)}, 64'd1);
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          checkOutput("rsp_owner", 64'(bus.rsp_valid), 64'(1) << sb[0].owner);
          checkOutput("rsp_data", 64'(bus.rsp_data), 64'(sb[0].data));
          checkOutput("rsp_tag", 64'(bus.rsp_tag), 64'(sb[0].tag));
          if ((bus.rsp_valid & bus.rsp_ready) != '0) void'(sb.pop_front());
        end
      end
      expectRsp = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.owner = i;
          e.data  = modelShift(bus.req_data[i], bus.req_shift[i].shift_type, bus.req_shift[i].amt);
          e.tag   = bus.req_tag[i];
          sb.push_back(e);
          grantLog.push_back(i);
          grantCyc.push_back(cycle);
          expectRsp = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAccept(input int idx, output int waited);
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready[idx] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready[idx]) checkOutput("req_accept_timeout", 64'd0, 64'd1);
    tick();
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] d, input logic [2:0] ty,
                               input logic [4:0] amt, input logic [TAG_W-1:0] tg);
    bus.req_valid[idx] = 1'b1;
    bus.req_data[idx]  = d;
    bus.req_shift[idx] = s_shift'({ty, amt});
    bus.req_tag[idx]   = tg;
  endtask

  task automatic sendReq(input int idx, input logic [31:0] d, input logic [2:0] ty,
                         input logic [4:0] amt, input logic [TAG_W-1:0] tg, output int waited);
    applyStimulus(idx, d, ty, amt, tg);
    waitAccept(idx, waited);
  endtask

  task automatic shiftCase(input string name, input int idx, input logic [31:0] d, input logic [2:0] ty,
                           input logic [4:0] amt, input logic [TAG_W-1:0] tg, input logic [31:0] want);
    int w;
    sendReq(idx, d, ty, amt, tg, w);
    checkOutput({name, "_grant_wait"}, 64'(w), 64'd0);
    @(negedge clk);
    checkOutput({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(1) << idx);
    checkOutput({name, "_rsp_data"}, 64'(bus.rsp_data), 64'(want));
    checkOutput({name, "_rsp_tag"}, 64'(bus.rsp_tag), 64'(tg));
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    int start;
    logic [NUM_REQ-1:0] acc;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_shift = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = '1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    checkOutput("reset_rsp_tag", 64'(bus.rsp_tag), 64'd0);
    tick();

    shiftCase("single_shl", 0, 32'h0000_00F0, SHIFT_SHL, 5'd4, 4'd3, 32'h0000_0F00);
    shiftCase("asr31", 1, 32'h8000_0000, SHIFT_ASR, 5'd31, 4'd1, 32'hFFFF_FFFF);
    shiftCase("shr31", 0, 32'h8000_0000, SHIFT_SHR, 5'd31, 4'd2, 32'h0000_0001);
    shiftCase("shl1", 1, 32'h8000_0000, SHIFT_SHL, 5'd1, 4'd4, 32'h0000_0000);
    shiftCase("unknown", 0, 32'h8000_0000, 3'd6, 5'd31, 4'd5, 32'h8000_0000);
    shiftCase("asr_amt0", 1, 32'h8000_0001, SHIFT_ASR, 5'd0, 4'd6, 32'h8000_0001);

    // Both requesters stay valid; each accepted one immediately presents a fresh payload
    start = grantLog.size();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, $urandom, 3'($urandom), 5'($urandom), TAG_W'($urandom));
    for (int n = 0; n < 40 && (grantLog.size() - start) < 4; n++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) applyStimulus(i, $urandom, 3'($urandom), 5'($urandom), TAG_W'($urandom));
      end
    end
    bus.req_valid = '0;
    checkOutput("fair_count", 64'(grantLog.size() - start >= 4), 64'd1);
    if (grantLog.size() - start >= 4) begin
      for (int k = 0; k < 4; k++) checkOutput("fair_grant", 64'(grantLog[start + k]), 64'(k % 2));
      for (int k = 1; k < 4; k++)
        checkOutput("fair_gap", 64'(grantCyc[start + k] - grantCyc[start + k - 1]), 64'(GRANT_GAP));
    end
    repeat (3) tick();

    // Backpressure on owner 1 while requester 0 waits
    bus.rsp_ready = 2'b01;
    sendReq(1, 32'hF000_0001, SHIFT_SHR, 5'd4, 4'hA, w);
    checkOutput("bp_grant_wait", 64'(w), 64'd0);
    applyStimulus(0, 32'h0000_0001, SHIFT_ASL, 5'd31, 4'h5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 64'(bus.rsp_valid), 64'd2);
      checkOutput("bp_rsp_data", 64'(bus.rsp_data), 64'h0F00_0000);
      checkOutput("bp_rsp_tag", 64'(bus.rsp_tag), 64'hA);
      checkOutput("bp_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.rsp_ready = '1;
    waitAccept(0, w);
    checkOutput("bp_next_grant_wait", 64'(w), 64'(BP_WAIT));
    repeat (2) tick();

    // Reset while holding a response
    bus.rsp_ready = '0;
    sendReq(0, 32'h0000_FFFF, SHIFT_SHL, 5'd16, 4'h7, w);
    @(negedge clk);
    checkOutput("rst_pre_valid", 64'(bus.rsp_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = '1;
    @(negedge clk);
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    tick();
    applyStimulus(0, 32'h1234_5678, SHIFT_ASR, 5'd8, 4'h1);
    applyStimulus(1, 32'h8765_4321, SHIFT_ASR, 5'd8, 4'h2);
    waitAccept(0, w);
    checkOutput("rst_first_grant_wait", 64'(w), 64'd0);
    checkOutput("rst_first_grant", 64'(grantLog[grantLog.size() - 1]), 64'd0);
    waitAccept(1, w);
    checkOutput("rst_second_grant", 64'(grantLog[grantLog.size() - 1]), 64'd1);
    repeat (2) tick();

    // Sparse requests leave ptr at 1, so a tie afterwards goes to requester 1
    sendReq(1, 32'h0000_0003, SHIFT_SHL, 5'd2, 4'h8, w);
    checkOutput("sparse_req1_wait", 64'(w), 64'd0);
    tick();
    sendReq(0, 32'hC000_0000, SHIFT_ASR, 5'd30, 4'h9, w);
    checkOutput("sparse_req0_wait", 64'(w), 64'd0);
    tick();
    applyStimulus(0, 32'h0000_0100, SHIFT_SHR, 5'd8, 4'hB);
    applyStimulus(1, 32'h0000_0100, SHIFT_SHL, 5'd8, 4'hC);
    waitAccept(1, w);
    checkOutput("sparse_tie_grant_wait", 64'(w), 64'd0);
    checkOutput("sparse_tie_grant", 64'(grantLog[grantLog.size() - 1]), 64'd1);
    waitAccept(0, w);
    repeat (2) tick();

    // Random operations with random response stalls
    for (int k = 0; k < 16; k++) begin
      sendReq($urandom_range(0, NUM_REQ - 1), $urandom, 3'($urandom), 5'($urandom), TAG_W'($urandom), w);
      bus.rsp_ready = 2'($urandom);
      tick();
      bus.rsp_ready = '1;
      tick();
    end

    repeat (2) tick();
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
